// File: rtl/s5mlab_fifo_rd_pkg.sv
// Shared constants and helpers for the show-ahead FIFO that drains an s5mlab array.
package s5mlab_fifo_pkg;

    localparam int ADDR_WIDTH_DEF = 5;
    localparam int DEPTH          = 1 << ADDR_WIDTH_DEF;
    localparam int CAPACITY       = DEPTH + 1;

    // One extra pointer bit tells full from empty when the low bits match.
    function automatic int ptr_width(input int addr_width);
        return addr_width + 1;
    endfunction

endpackage

// File: rtl/s5mlab_fifo_rd_mlab.sv
// MLAB-style storage: registered write port, asynchronous read port.
module s5mlab #(
    parameter int WIDTH      = 20,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  wclk,
    input  logic                  wena,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [WIDTH-1:0]      wdata,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [WIDTH-1:0]      rdata
);

    logic [WIDTH-1:0] mem [1 << ADDR_WIDTH];

    always_ff @(posedge wclk) begin
        if (wena) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/s5mlab_fifo_rd.sv
// Show-ahead FIFO: writes staged into the MLAB, head word captured into a registered
// valid/ready output stage.
module s5mlab_fifo_rd
    import s5mlab_fifo_pkg::*;
#(
    parameter int WIDTH      = 20,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  srst,
    input  logic [WIDTH-1:0]      din,
    input  logic                  din_valid,
    output logic                  din_ready,
    output logic [WIDTH-1:0]      dout,
    output logic                  dout_valid,
    input  logic                  dout_ready,
    output logic [ADDR_WIDTH:0]   used_words
);

    localparam int PW = ptr_width(ADDR_WIDTH);
    localparam logic [PW-1:0] FULL_LEVEL = PW'(1) << ADDR_WIDTH;

    logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]         wr_cmt_q, wr_cmt_d;
    logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
    logic                  wena_q;
    logic [ADDR_WIDTH-1:0] waddr_q;
    logic [WIDTH-1:0]      wdata_q;
    logic [WIDTH-1:0]      rdata;
    logic [WIDTH-1:0]      dout_q, dout_d;
    logic                  dout_valid_q, dout_valid_d;
    logic [ADDR_WIDTH:0]   used_q, used_d;
    logic                  accept, pop, have_data, load;

    // Full counts MLAB occupancy only; the output register adds the extra slot.
    assign din_ready = !srst && ((wr_ptr_q - rd_ptr_q) != FULL_LEVEL);
    assign accept    = din_valid && din_ready;
    assign pop       = dout_valid_q && dout_ready;
    assign have_data = (wr_cmt_q != rd_ptr_q);
    assign load      = have_data && (!dout_valid_q || dout_ready);

    always_comb begin
        wr_ptr_d     = wr_ptr_q + PW'(accept);
        wr_cmt_d     = wr_cmt_q + PW'(wena_q);
        rd_ptr_d     = rd_ptr_q + PW'(load);
        dout_d       = dout_q;
        dout_valid_d = dout_valid_q;
        if (load) begin
            dout_d       = rdata;
            dout_valid_d = 1'b1;
        end else if (pop) begin
            dout_valid_d = 1'b0;
        end
        used_d = (wr_ptr_d - rd_ptr_d) + PW'(dout_valid_d);
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            wr_ptr_q     <= '0;
            wr_cmt_q     <= '0;
            rd_ptr_q     <= '0;
            wena_q       <= 1'b0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            used_q       <= '0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            wr_cmt_q     <= wr_cmt_d;
            rd_ptr_q     <= rd_ptr_d;
            wena_q       <= accept;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            used_q       <= used_d;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            wdata_q <= din;
            waddr_q <= wr_ptr_q[ADDR_WIDTH-1:0];
        end
    end

    s5mlab #(
        .WIDTH      (WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_mlab (
        .wclk  (clk),
        .wena  (wena_q),
        .waddr (waddr_q),
        .wdata (wdata_q),
        .raddr (rd_ptr_q[ADDR_WIDTH-1:0]),
        .rdata (rdata)
    );

    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign used_words = used_q;

endmodule

// File: tb/tb_s5mlab_fifo_rd.sv
// Bench for s5mlab_fifo_rd: directed scenarios plus random traffic against a queue model.
module tb_s5mlab_fifo_rd;

    localparam int WIDTH = 20;
    localparam int AW    = 5;
    localparam int CAP   = (1 << AW) + 1;

    logic             clk = 1'b0;
    logic             srst = 1'b1;
    logic [WIDTH-1:0] din = '0;
    logic             din_valid = 1'b0;
    logic             din_ready;
    logic [WIDTH-1:0] dout;
    logic             dout_valid;
    logic             dout_ready = 1'b0;
    logic [AW:0]      used_words;

    s5mlab_fifo_rd #(.WIDTH(WIDTH), .ADDR_WIDTH(AW)) dut (
        .clk        (clk),
        .srst       (srst),
        .din        (din),
        .din_valid  (din_valid),
        .din_ready  (din_ready),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .used_words (used_words)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [WIDTH-1:0] data;
        int               t;
    } entry_t;

    entry_t model[$];
    int cyc = 0;
    int n_checks = 0;
    int n_fail = 0;
    bit acc, pop, pop_empty;
    logic [WIDTH-1:0] pop_got, pop_exp;

    // One clock: sample handshakes mid-cycle, update the model at the edge.
    task automatic step();
        logic [WIDTH-1:0] acc_data;
        bit rst_now;
        entry_t e;
        @(negedge clk);
        acc       = din_valid && din_ready;
        pop       = dout_valid && dout_ready;
        acc_data  = din;
        rst_now   = srst;
        pop_got   = dout;
        pop_exp   = '0;
        pop_empty = pop && (model.size() == 0);
        if (pop && model.size() > 0) pop_exp = model[0].data;
        @(posedge clk);
        cyc++;
        if (rst_now) begin
            model.delete();
        end else begin
            if (pop && model.size() > 0) void'(model.pop_front());
            if (acc) begin
                e.data = acc_data;
                e.t    = cyc;
                model.push_back(e);
            end
        end
        #1;
    endtask

    task automatic test_reset();
        srst = 1'b1;
        step();
        step();
        n_checks++;
        if (dout_valid !== 1'b0) begin n_fail++; $display("FAIL reset_dout_valid: got %b expected 0", dout_valid); end
        n_checks++;
        if (used_words !== '0) begin n_fail++; $display("FAIL reset_used: got %0d expected 0", used_words); end
        n_checks++;
        if (dout !== '0) begin n_fail++; $display("FAIL reset_dout: got %h expected 0", dout); end
        n_checks++;
        if (din_ready !== 1'b0) begin n_fail++; $display("FAIL reset_din_ready: got %b expected 0", din_ready); end
        srst = 1'b0;
        #1;
        n_checks++;
        if (din_ready !== 1'b1) begin n_fail++; $display("FAIL post_reset_din_ready: got %b expected 1", din_ready); end
        $display("test_reset done");
    endtask

    task automatic test_single();
        din = 20'h12345;
        din_valid = 1'b1;
        step();
        din_valid = 1'b0;
        n_checks++;
        if (!acc) begin n_fail++; $display("FAIL single_accept: got %b expected 1", acc); end
        n_checks++;
        if (used_words !== 6'd1) begin n_fail++; $display("FAIL single_used: got %0d expected 1", used_words); end
        n_checks++;
        if (dout_valid !== 1'b0) begin n_fail++; $display("FAIL single_lat1: dout_valid got %b expected 0", dout_valid); end
        step();
        n_checks++;
        if (dout_valid !== 1'b0) begin n_fail++; $display("FAIL single_lat2: dout_valid got %b expected 0", dout_valid); end
        step();
        n_checks++;
        if (dout_valid !== 1'b1 || dout !== 20'h12345) begin
            n_fail++; $display("FAIL single_out: got valid=%b data=%h expected valid=1 data=12345", dout_valid, dout);
        end
        dout_ready = 1'b1;
        step();
        dout_ready = 1'b0;
        n_checks++;
        if (!pop || pop_got !== 20'h12345 || used_words !== '0) begin
            n_fail++; $display("FAIL single_pop: got pop=%b data=%h used=%0d expected 1/12345/0", pop, pop_got, used_words);
        end
        $display("test_single done");
    endtask

    task automatic test_fill();
        int n_acc = 0;
        dout_ready = 1'b0;
        for (int i = 0; i <= 40; i++) begin
            din = WIDTH'(i);
            din_valid = 1'b1;
            step();
            if (acc) n_acc++;
        end
        din_valid = 1'b0;
        n_checks++;
        if (n_acc != CAP) begin n_fail++; $display("FAIL fill_count: got %0d expected %0d", n_acc, CAP); end
        n_checks++;
        if (din_ready !== 1'b0) begin n_fail++; $display("FAIL fill_din_ready: got %b expected 0", din_ready); end
        n_checks++;
        if (used_words !== 6'(CAP)) begin n_fail++; $display("FAIL fill_used: got %0d expected %0d", used_words, CAP); end
        n_checks++;
        if (dout_valid !== 1'b1 || dout !== '0) begin
            n_fail++; $display("FAIL fill_head: got valid=%b data=%h expected 1/0", dout_valid, dout);
        end
        $display("test_fill done accepted=%0d", n_acc);
    endtask

    task automatic test_drain();
        dout_ready = 1'b1;
        for (int i = 0; i < CAP; i++) begin
            step();
            n_checks++;
            if (!pop || pop_got !== WIDTH'(i) || pop_got !== pop_exp) begin
                n_fail++; $display("FAIL drain_%0d: got pop=%b data=%h expected pop=1 data=%h", i, pop, pop_got, WIDTH'(i));
            end
            if (i == 1) begin
                n_checks++;
                if (din_ready !== 1'b1) begin n_fail++; $display("FAIL drain_release: din_ready got %b expected 1", din_ready); end
            end
        end
        dout_ready = 1'b0;
        n_checks++;
        if (used_words !== '0 || dout_valid !== 1'b0) begin
            n_fail++; $display("FAIL drain_end: got used=%0d valid=%b expected 0/0", used_words, dout_valid);
        end
        $display("test_drain done");
    endtask

    task automatic test_back_to_back();
        int n_pop = 0;
        int gaps = 0;
        int bad = 0;
        dout_ready = 1'b1;
        for (int i = 0; i < 205; i++) begin
            din_valid = (i < 200);
            din = WIDTH'(32'h1000 + i);
            step();
            if (pop) begin
                if (pop_got !== WIDTH'(32'h1000 + n_pop) || pop_empty) bad++;
                n_pop++;
            end else if (n_pop > 0 && n_pop < 200) begin
                gaps++;
            end
        end
        din_valid = 1'b0;
        dout_ready = 1'b0;
        n_checks++;
        if (n_pop != 200) begin n_fail++; $display("FAIL stream_count: got %0d expected 200", n_pop); end
        n_checks++;
        if (gaps != 0) begin n_fail++; $display("FAIL stream_gaps: got %0d expected 0", gaps); end
        n_checks++;
        if (bad != 0) begin n_fail++; $display("FAIL stream_order: got %0d bad words expected 0", bad); end
        $display("test_back_to_back done pops=%0d", n_pop);
    endtask

    task automatic test_random();
        logic [AW:0] exp_used;
        for (int i = 0; i < 10000; i++) begin
            din_valid  = 1'($urandom_range(0, 1));
            dout_ready = 1'($urandom_range(0, 1));
            din        = WIDTH'($urandom);
            step();
            exp_used = (AW + 1)'(model.size());
            n_checks++;
            if (used_words !== exp_used) begin
                n_fail++; $display("FAIL rand_used cyc=%0d: got %0d expected %0d", cyc, used_words, exp_used);
            end
            if (pop) begin
                n_checks++;
                if (pop_empty || pop_got !== pop_exp) begin
                    n_fail++; $display("FAIL rand_pop cyc=%0d: got %h expected %h empty=%b", cyc, pop_got, pop_exp, pop_empty);
                end
            end
            n_checks++;
            if (model.size() == 0) begin
                if (dout_valid !== 1'b0) begin n_fail++; $display("FAIL rand_valid cyc=%0d: got %b expected 0", cyc, dout_valid); end
            end else if (model[0].t <= cyc - 2) begin
                if (dout_valid !== 1'b1 || dout !== model[0].data) begin
                    n_fail++; $display("FAIL rand_head cyc=%0d: got valid=%b data=%h expected 1/%h", cyc, dout_valid, dout, model[0].data);
                end
            end else if (dout_valid === 1'b1 && dout !== model[0].data) begin
                n_fail++; $display("FAIL rand_head_early cyc=%0d: got %h expected %h", cyc, dout, model[0].data);
            end
            if (model.size() == CAP || model.size() < CAP - 1) begin
                n_checks++;
                if (din_ready !== (model.size() < CAP - 1)) begin
                    n_fail++; $display("FAIL rand_din_ready cyc=%0d: got %b with %0d held", cyc, din_ready, model.size());
                end
            end
        end
        din_valid = 1'b0;
        dout_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            step();
            if (pop) begin
                n_checks++;
                if (pop_empty || pop_got !== pop_exp) begin
                    n_fail++; $display("FAIL rand_drain: got %h expected %h", pop_got, pop_exp);
                end
            end
        end
        dout_ready = 1'b0;
        n_checks++;
        if (used_words !== '0 || dout_valid !== 1'b0) begin
            n_fail++; $display("FAIL rand_end: got used=%0d valid=%b expected 0/0", used_words, dout_valid);
        end
        $display("test_random done");
    endtask

    task automatic test_reset_mid();
        dout_ready = 1'b0;
        for (int i = 0; i < 11; i++) begin
            din = WIDTH'(32'h500 + i);
            din_valid = 1'b1;
            step();
        end
        din_valid = 1'b0;
        srst = 1'b1;
        step();
        n_checks++;
        if (din_ready !== 1'b0) begin n_fail++; $display("FAIL mid_rst_din_ready: got %b expected 0", din_ready); end
        srst = 1'b0;
        #1;
        n_checks++;
        if (dout_valid !== 1'b0 || used_words !== '0) begin
            n_fail++; $display("FAIL mid_rst_state: got valid=%b used=%0d expected 0/0", dout_valid, used_words);
        end
        din = 20'hABCDE;
        din_valid = 1'b1;
        step();
        din_valid = 1'b0;
        step();
        step();
        n_checks++;
        if (dout_valid !== 1'b1 || dout !== 20'hABCDE || used_words !== 6'd1) begin
            n_fail++; $display("FAIL mid_rst_first: got valid=%b data=%h used=%0d expected 1/abcde/1", dout_valid, dout, used_words);
        end
        dout_ready = 1'b1;
        step();
        step();
        step();
        dout_ready = 1'b0;
        n_checks++;
        if (dout_valid !== 1'b0 || used_words !== '0) begin
            n_fail++; $display("FAIL mid_rst_leak: got valid=%b used=%0d expected 0/0", dout_valid, used_words);
        end
        $display("test_reset_mid done");
    endtask

    initial begin
        test_reset();
        test_single();
        test_fill();
        test_drain();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
